// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: parses a framed image (word count, LE words, XOR checksum)
// and writes it into the instruction memory, holding the core in reset until it is accepted.
module instr_mem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WORDS  = 65536,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_rst_n
);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [32:0]           MAX_N = 33'(MAX_WORDS);

    state_t                  state_q, state_d;
    logic [1:0]              byte_q, byte_d;
    logic [23:0]             asm_q, asm_d;
    logic [31:0]             n_q, n_d;
    logic [31:0]             idx_q, idx_d;
    logic [7:0]              csum_q, csum_d;
    logic                    we_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [DATA_WIDTH-1:0]   wdata_d;
    logic                    in_frame_d;
    logic                    accept;
    logic [31:0]             full_word;

    assign accept    = rx_valid && rx_ready;
    assign full_word = {rx_data, asm_q};

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        asm_d   = asm_q;
        n_d     = n_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN;
                    byte_d  = 2'd0;
                    asm_d   = 24'd0;
                    n_d     = 32'd0;
                    idx_d   = 32'd0;
                    csum_d  = 8'd0;
                end
            end

            LEN: begin
                if (accept) begin
                    csum_d = csum_q ^ rx_data;
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        n_d = full_word;
                        if (full_word == 32'd0) begin
                            state_d = CSUM;
                        end else if ({1'b0, full_word} > MAX_N) begin
                            state_d = ERR;
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        case (byte_q)
                            2'd0:    asm_d[7:0]   = rx_data;
                            2'd1:    asm_d[15:8]  = rx_data;
                            default: asm_d[23:16] = rx_data;
                        endcase
                    end
                end
            end

            DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ rx_data;
                    byte_d = byte_q + 2'd1;
                    // The write strobe is registered, so it lands the cycle after the last byte.
                    if (byte_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = DATA_WIDTH'(full_word);
                        addr_d  = BASE + ADDR_WIDTH'({idx_q, 2'b00});
                        idx_d   = idx_q + 32'd1;
                        if (idx_q + 32'd1 == n_q) begin
                            state_d = CSUM;
                        end
                    end else begin
                        case (byte_q)
                            2'd0:    asm_d[7:0]   = rx_data;
                            2'd1:    asm_d[15:8]  = rx_data;
                            default: asm_d[23:16] = rx_data;
                        endcase
                    end
                end
            end

            CSUM: begin
                if (accept) begin
                    state_d = (rx_data == csum_q) ? DONE : ERR;
                end
            end

            default: state_d = IDLE;
        endcase

        in_frame_d = (state_d == LEN) || (state_d == DATA) || (state_d == CSUM);
    end

    // Status outputs are registered from the next state so they align with the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            byte_q    <= 2'd0;
            asm_q     <= 24'd0;
            n_q       <= 32'd0;
            idx_q     <= 32'd0;
            csum_q    <= 8'd0;
            rx_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_rst_n <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            asm_q     <= asm_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            rx_ready  <= in_frame_d;
            busy      <= in_frame_d;
            done      <= (state_d == DONE);
            error     <= (state_d == ERR);
            cpu_rst_n <= (state_d == DONE);
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
        end
    end

endmodule
